// File: rtl/count_sequencer.sv
// Run-control sequencer for an up-counter: start/stop/pause, a programmable terminal count,
// a prescaler, and one-shot or periodic operation.
module count_sequencer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  tc_pulse,
    output logic                  done
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  mode_q, mode_d;
    logic                  tc_q, tc_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            pcnt_q     <= '0;
            limit_q    <= '0;
            prescale_q <= '0;
            mode_q     <= 1'b0;
            tc_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            limit_q    <= limit_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            tc_q       <= tc_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pcnt_d     = pcnt_q;
        limit_d    = limit_q;
        prescale_d = prescale_q;
        mode_d     = mode_q;
        tc_d       = 1'b0;
        done_d     = done_q;

        if (stop) begin
            // Stop beats a terminal step on the same edge: no pulse, no DONE.
            state_d = StIdle;
            count_d = '0;
            pcnt_d  = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        limit_d    = limit;
                        prescale_d = prescale;
                        mode_d     = mode;
                        count_d    = '0;
                        pcnt_d     = '0;
                        done_d     = 1'b0;
                        state_d    = StRun;
                    end
                end
                StRun: begin
                    // Pause is checked first so the freezing edge never takes a step.
                    if (pause) begin
                        state_d = StHold;
                    end else if (pcnt_q == prescale_q) begin
                        pcnt_d = '0;
                        if (count_q < limit_q) begin
                            count_d = count_q + WIDTH'(1);
                        end else begin
                            tc_d = 1'b1;
                            if (mode_q) begin
                                count_d = '0;
                            end else begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q + PRESCALE_W'(1);
                    end
                end
                StHold: begin
                    if (!pause) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        count    = count_q;
        state    = state_q;
        busy     = (state_q == StRun) || (state_q == StHold);
        tc_pulse = tc_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: reset, one-shot, periodic, pause, stop and
// shadow-register behaviour against hand-computed expectations.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode;
    logic [3:0] limit;
    logic [3:0] prescale;
    logic [3:0] count;
    logic [1:0] state;
    logic       busy;
    logic       tc_pulse;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    count_sequencer #(
        .WIDTH      (4),
        .PRESCALE_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .limit    (limit),
        .prescale (prescale),
        .count    (count),
        .state    (state),
        .busy     (busy),
        .tc_pulse (tc_pulse),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".count"}, int'(count), 0);
        check_eq({tag, ".state"}, int'(state), 0);
        check_eq({tag, ".busy"}, int'(busy), 0);
        check_eq({tag, ".done"}, int'(done), 0);
        check_eq({tag, ".tc"}, int'(tc_pulse), 0);
    endtask

    task automatic do_start(input logic m, input int lim, input int pre);
        mode     = m;
        limit    = 4'(lim);
        prescale = 4'(pre);
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 1'b0; limit = '0; prescale = '0;

        // Power-up reset.
        tick(2);
        check_idle("por");
        reset = 1'b0;

        // Reset mid-run at count 5.
        do_start(1'b1, 15, 0);
        tick(5);
        check_eq("prerst.count", int'(count), 5);
        reset = 1'b1;
        tick(2);
        check_idle("midrst");
        reset = 1'b0;

        // One-shot, limit 3, prescale 0.
        do_start(1'b0, 3, 0);
        check_eq("os.start.state", int'(state), 1);
        check_eq("os.start.count", int'(count), 0);
        check_eq("os.start.busy", int'(busy), 1);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check_eq($sformatf("os.e%0d.count", i), int'(count), i);
            check_eq($sformatf("os.e%0d.tc", i), int'(tc_pulse), 0);
        end
        tick(1);
        check_eq("os.e4.tc", int'(tc_pulse), 1);
        check_eq("os.e4.done", int'(done), 1);
        check_eq("os.e4.state", int'(state), 3);
        check_eq("os.e4.count", int'(count), 3);
        tick(1);
        check_eq("os.e5.tc", int'(tc_pulse), 0);
        check_eq("os.e5.state", int'(state), 3);
        check_eq("os.e5.count", int'(count), 3);
        check_eq("os.e5.busy", int'(busy), 0);
        do_stop();
        check_idle("os.stop");

        // Periodic, limit 2, prescale 1.
        begin
            int exp_cnt [12] = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};
            do_start(1'b1, 2, 1);
            check_eq("per.e0.count", int'(count), 0);
            for (int i = 0; i < 12; i++) begin
                tick(1);
                check_eq($sformatf("per.e%0d.count", i + 1), int'(count), exp_cnt[i]);
                check_eq($sformatf("per.e%0d.tc", i + 1), int'(tc_pulse),
                         ((i + 1) % 6 == 0) ? 1 : 0);
            end
            do_stop();
        end

        // Pause at count 4, periodic limit 15, prescale 2; freeze with prescale phase 1.
        do_start(1'b1, 15, 2);
        tick(12);
        check_eq("pau.pre.count", int'(count), 4);
        tick(1);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq($sformatf("pau.h%0d.state", i), int'(state), 2);
            check_eq($sformatf("pau.h%0d.count", i), int'(count), 4);
            check_eq($sformatf("pau.h%0d.busy", i), int'(busy), 1);
        end
        pause = 1'b0;
        tick(1);
        check_eq("pau.rel.state", int'(state), 1);
        check_eq("pau.rel.count", int'(count), 4);
        tick(1);
        check_eq("pau.r1.count", int'(count), 4);
        tick(1);
        check_eq("pau.r2.count", int'(count), 5);
        do_stop();

        // Stop coinciding with the one-shot terminal step.
        do_start(1'b0, 1, 0);
        tick(1);
        check_eq("stp.e1.count", int'(count), 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check_idle("stp.term");
        tick(1);
        check_idle("stp.after");

        // Shadowing: input changes and a re-start during RUN are ignored.
        do_start(1'b0, 3, 0);
        limit = 4'd9; mode = 1'b1; prescale = 4'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("shd.e1.count", int'(count), 1);
        tick(2);
        check_eq("shd.e3.count", int'(count), 3);
        tick(1);
        check_eq("shd.e4.state", int'(state), 3);
        check_eq("shd.e4.done", int'(done), 1);
        check_eq("shd.e4.count", int'(count), 3);

        // Restart from DONE with new values: periodic, limit 0, prescale 3.
        do_start(1'b1, 0, 3);
        check_eq("rst.e0.state", int'(state), 1);
        check_eq("rst.e0.done", int'(done), 0);
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            check_eq($sformatf("lim0.e%0d.tc", i), int'(tc_pulse), (i % 4 == 0) ? 1 : 0);
            check_eq($sformatf("lim0.e%0d.count", i), int'(count), 0);
        end
        do_stop();
        check_idle("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
